// File: rtl/compare_unit_pipe.sv
// -----------------------------------------------------------------------------
// compare_unit_pipe
//   Pipelined magnitude comparator used as the compare lane of the ALU
//   datapath. Operands A/B are captured in stage 1, compared combinationally,
//   and the {GT,EQ,LT} result plus the selected flag is registered in stage 2.
//   Both sides use valid/ready handshakes; delivered results are tallied in
//   three saturating per-outcome counters.
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   asynchronous active-low reset
//   IN_VALID   in   A/B/S2/S3/SIGNED_EN valid this cycle
//   IN_READY   out  block accepts input this cycle (combinational on OUT_READY)
//   A, B       in   WIDTH-bit operands
//   S2         in   1 = drive EQ onto OUT
//   S3         in   when S2=0: 0 = GT, 1 = LT
//   SIGNED_EN  in   1 = two's-complement compare, 0 = unsigned
//   CNT_CLR    in   synchronous clear of all counters (wins over increment)
//   OUT_VALID  out  OUT/FLAGS hold a valid result
//   OUT_READY  in   downstream accepts the result
//   OUT        out  {WIDTH-1 zeros, selected flag}
//   FLAGS      out  {GT, EQ, LT}, one-hot
//   GT_CNT, LT_CNT, EQ_CNT  out  saturating counts of delivered outcomes
// -----------------------------------------------------------------------------
module compare_unit_pipe #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 S2,
  input  logic                 S3,
  input  logic                 SIGNED_EN,
  input  logic                 CNT_CLR,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [WIDTH-1:0]     OUT,
  output logic [2:0]           FLAGS,
  output logic [CNT_WIDTH-1:0] GT_CNT,
  output logic [CNT_WIDTH-1:0] LT_CNT,
  output logic [CNT_WIDTH-1:0] EQ_CNT
);

  // Sign-extend (or zero-extend) by one bit so a single signed compare
  // covers both modes: in unsigned mode the extra bit is 0 and the value
  // stays non-negative.
  function automatic logic [2:0] f_compare(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b,
                                           input logic             sgn);
    logic signed [WIDTH:0] ea;
    logic signed [WIDTH:0] eb;
    ea = $signed({sgn & a[WIDTH-1], a});
    eb = $signed({sgn & b[WIDTH-1], b});
    f_compare = {ea > eb, ea == eb, ea < eb};
  endfunction

  function automatic logic f_select(input logic [2:0] flags,
                                    input logic       s2,
                                    input logic       s3);
    if (s2)      f_select = flags[1];
    else if (s3) f_select = flags[0];
    else         f_select = flags[2];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] f_sat_inc(input logic [CNT_WIDTH-1:0] c);
    f_sat_inc = (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  logic                 r_vld_p1;
  logic [WIDTH-1:0]     r_a_p1;
  logic [WIDTH-1:0]     r_b_p1;
  logic                 r_s2_p1;
  logic                 r_s3_p1;
  logic                 r_sgn_p1;

  logic                 r_vld_p2;
  logic [2:0]           r_flags_p2;
  logic [WIDTH-1:0]     r_out_p2;

  logic [CNT_WIDTH-1:0] r_gt_cnt;
  logic [CNT_WIDTH-1:0] r_lt_cnt;
  logic [CNT_WIDTH-1:0] r_eq_cnt;

  logic                 w_adv2;
  logic                 w_adv1;
  logic                 w_accept;
  logic                 w_out_hs;
  logic [2:0]           w_flags_p1;
  logic                 w_sel_p1;

  // Stage 2 can take new data when empty or draining; stage 1 when empty
  // or when stage 2 is advancing.
  assign w_adv2   = ~r_vld_p2 | OUT_READY;
  assign w_adv1   = ~r_vld_p1 | w_adv2;
  assign w_accept = IN_VALID & w_adv1;
  assign w_out_hs = r_vld_p2 & OUT_READY;

  assign IN_READY = w_adv1;

  // ---- stage 1: operand capture ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_vld_p1 <= 1'b0;
    end else if (w_adv1) begin
      r_vld_p1 <= IN_VALID;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_a_p1   <= A;
      r_b_p1   <= B;
      r_s2_p1  <= S2;
      r_s3_p1  <= S3;
      r_sgn_p1 <= SIGNED_EN;
    end
  end

  // ---- compare between stage 1 and stage 2 ----
  assign w_flags_p1 = f_compare(r_a_p1, r_b_p1, r_sgn_p1);
  assign w_sel_p1   = f_select(w_flags_p1, r_s2_p1, r_s3_p1);

  // ---- stage 2: compare result ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_vld_p2   <= 1'b0;
      r_flags_p2 <= 3'b000;
      r_out_p2   <= '0;
    end else if (w_adv2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_flags_p2 <= w_flags_p1;
        r_out_p2   <= WIDTH'(w_sel_p1);
      end
    end
  end

  // ---- outcome counters on output handshake ----
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_gt_cnt <= '0;
      r_lt_cnt <= '0;
      r_eq_cnt <= '0;
    end else if (CNT_CLR) begin
      r_gt_cnt <= '0;
      r_lt_cnt <= '0;
      r_eq_cnt <= '0;
    end else if (w_out_hs) begin
      if (r_flags_p2[2]) r_gt_cnt <= f_sat_inc(r_gt_cnt);
      if (r_flags_p2[1]) r_eq_cnt <= f_sat_inc(r_eq_cnt);
      if (r_flags_p2[0]) r_lt_cnt <= f_sat_inc(r_lt_cnt);
    end
  end

  assign OUT_VALID = r_vld_p2;
  assign OUT       = r_out_p2;
  assign FLAGS     = r_flags_p2;
  assign GT_CNT    = r_gt_cnt;
  assign LT_CNT    = r_lt_cnt;
  assign EQ_CNT    = r_eq_cnt;

endmodule

// File: tb/tb_compare_unit_pipe.sv
// -----------------------------------------------------------------------------
// tb_compare_unit_pipe
//   Scoreboard bench for compare_unit_pipe. An input monitor pushes the
//   reference result of every accepted vector; an output monitor pops and
//   compares on every delivered result and tracks the expected counters.
//   A second instance with CNT_WIDTH=2 exercises counter saturation/clear.
// -----------------------------------------------------------------------------
module tb_compare_unit_pipe;

  localparam int W    = 4;
  localparam int CW   = 8;
  localparam int MAXC = (1 << CW) - 1;

  typedef struct packed {
    logic [W-1:0] out;
    logic [2:0]   flags;
  } exp_t;

  logic          CLK;
  logic          RST;
  logic          IN_VALID, IN_READY;
  logic [W-1:0]  A, B;
  logic          S2, S3, SIGNED_EN, CNT_CLR;
  logic          OUT_VALID, OUT_READY;
  logic [W-1:0]  OUT;
  logic [2:0]    FLAGS;
  logic [CW-1:0] GT_CNT, LT_CNT, EQ_CNT;

  logic          IN_VALID_2, IN_READY_2;
  logic [W-1:0]  A_2, B_2;
  logic          S2_2, S3_2, SIGNED_EN_2, CNT_CLR_2;
  logic          OUT_VALID_2, OUT_READY_2;
  logic [W-1:0]  OUT_2;
  logic [2:0]    FLAGS_2;
  logic [1:0]    GT_CNT_2, LT_CNT_2, EQ_CNT_2;

  compare_unit_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .S2(S2), .S3(S3), .SIGNED_EN(SIGNED_EN), .CNT_CLR(CNT_CLR),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT), .FLAGS(FLAGS),
    .GT_CNT(GT_CNT), .LT_CNT(LT_CNT), .EQ_CNT(EQ_CNT));

  compare_unit_pipe #(.WIDTH(W), .CNT_WIDTH(2)) dut2 (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID_2), .IN_READY(IN_READY_2),
    .A(A_2), .B(B_2), .S2(S2_2), .S3(S3_2), .SIGNED_EN(SIGNED_EN_2), .CNT_CLR(CNT_CLR_2),
    .OUT_VALID(OUT_VALID_2), .OUT_READY(OUT_READY_2), .OUT(OUT_2), .FLAGS(FLAGS_2),
    .GT_CNT(GT_CNT_2), .LT_CNT(LT_CNT_2), .EQ_CNT(EQ_CNT_2));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  int   delivered = 0;
  int   delivered_2 = 0;
  int   m_gt = 0, m_eq = 0, m_lt = 0;
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: interpret operands as plain integers, apply the rules.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s2, input logic s3, input logic sgn);
    exp_t e;
    int ia, ib;
    bit sel;
    ia = int'(a);
    ib = int'(b);
    if (sgn && ia >= (1 << (W-1))) ia -= (1 << W);
    if (sgn && ib >= (1 << (W-1))) ib -= (1 << W);
    e.flags = {ia > ib, ia == ib, ia < ib};
    if (s2)      sel = (ia == ib);
    else if (s3) sel = (ia < ib);
    else         sel = (ia > ib);
    e.out = sel ? W'(1) : W'(0);
    return e;
  endfunction

  initial forever begin
    @(posedge CLK);
    cyc++;
  end

  // Input monitor: record expected result of each accepted vector.
  initial forever begin
    @(negedge CLK);
    if (RST && IN_VALID && IN_READY)
      sb_q.push_back(model(A, B, S2, S3, SIGNED_EN));
  end

  // Output monitor: compare delivered results and counters.
  initial forever begin
    exp_t e;
    bit   hs;
    @(negedge CLK);
    if (RST) begin
      check("gt_cnt", int'(GT_CNT), m_gt);
      check("eq_cnt", int'(EQ_CNT), m_eq);
      check("lt_cnt", int'(LT_CNT), m_lt);
      hs = OUT_VALID && OUT_READY;
      e  = '0;
      if (hs) begin
        delivered++;
        if (sb_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("out", int'(OUT), int'(e.out));
          check("flags", int'(FLAGS), int'(e.flags));
        end
      end
      if (CNT_CLR) begin
        m_gt = 0; m_eq = 0; m_lt = 0;
      end else if (hs) begin
        if (e.flags[2] && m_gt < MAXC) m_gt++;
        if (e.flags[1] && m_eq < MAXC) m_eq++;
        if (e.flags[0] && m_lt < MAXC) m_lt++;
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    if (RST && OUT_VALID_2 && OUT_READY_2) delivered_2++;
  end

  // Present a vector and return 1 ns after the edge that accepts it.
  task automatic send_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s2, input logic s3, input logic sgn);
    bit ok;
    A = a; B = b; S2 = s2; S3 = s3; SIGNED_EN = sgn;
    IN_VALID = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge CLK);
      ok = IN_READY;
      @(posedge CLK);
      #1;
      if (ok) break;
      if (t == 199) check("accept_timeout", 0, 1);
    end
    IN_VALID = 1'b0;
  endtask

  task automatic send_rand();
    send_vec(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  bit          done_rand;
  int          acc, c0, d0, s0;
  bit          ok;
  logic [W-1:0] held_out;
  logic [2:0]  held_flags;
  bit          held;

  initial begin
    RST = 1'b1;
    IN_VALID = 0; A = 0; B = 0; S2 = 0; S3 = 0; SIGNED_EN = 0; CNT_CLR = 0; OUT_READY = 1;
    IN_VALID_2 = 0; A_2 = 0; B_2 = 0; S2_2 = 0; S3_2 = 0; SIGNED_EN_2 = 0; CNT_CLR_2 = 0; OUT_READY_2 = 1;
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_out_valid", int'(OUT_VALID), 0);
    check("rst_out", int'(OUT), 0);
    check("rst_flags", int'(FLAGS), 0);
    check("rst_cnt_sum", int'(GT_CNT) + int'(LT_CNT) + int'(EQ_CNT), 0);
    check("rst_in_ready", int'(IN_READY), 1);
    #2 RST = 1'b1;

    // Unsigned 9 > 3, select GT; exact two-edge latency.
    send_vec(4'd9, 4'd3, 1'b0, 1'b0, 1'b0);
    check("t1_valid_after_accept", int'(OUT_VALID), 0);
    tick();
    check("t1_valid", int'(OUT_VALID), 1);
    check("t1_out", int'(OUT), 1);
    check("t1_flags", int'(FLAGS), 3'b100);
    tick();
    check("t1_gt_cnt", int'(GT_CNT), 1);

    // -1 vs 1 signed (LT) then unsigned (GT), back to back.
    send_vec(4'b1111, 4'b0001, 1'b0, 1'b1, 1'b1);
    send_vec(4'b1111, 4'b0001, 1'b0, 1'b1, 1'b0);
    check("t2_signed_out", int'(OUT), 1);
    check("t2_signed_flags", int'(FLAGS), 3'b001);
    tick();
    check("t2_unsigned_out", int'(OUT), 0);
    check("t2_unsigned_flags", int'(FLAGS), 3'b100);
    repeat (2) tick();

    // Back-to-back stream of 8: one accept and one delivery per cycle.
    c0 = cyc; d0 = delivered;
    s0 = int'(GT_CNT) + int'(LT_CNT) + int'(EQ_CNT);
    repeat (8) send_rand();
    check("t3_accept_cycles", cyc - c0, 8);
    repeat (2) tick();
    check("t3_delivered", delivered - d0, 8);
    check("t3_cnt_delta", int'(GT_CNT) + int'(LT_CNT) + int'(EQ_CNT) - s0, 8);

    // Stall: OUT_READY low for 5 cycles with input held valid.
    OUT_READY = 0; acc = 0; held = 0;
    A = W'($urandom); B = W'($urandom); S2 = 0; S3 = 1'($urandom); SIGNED_EN = 1'($urandom);
    IN_VALID = 1;
    repeat (5) begin
      @(negedge CLK);
      ok = IN_READY;
      @(posedge CLK);
      #1;
      if (OUT_VALID && !held) begin
        held = 1; held_out = OUT; held_flags = FLAGS;
      end
      if (ok) begin
        acc++;
        A = W'($urandom); B = W'($urandom); S3 = 1'($urandom);
      end
    end
    check("t4_accepts", acc, 2);
    check("t4_in_ready", int'(IN_READY), 0);
    check("t4_out_valid", int'(OUT_VALID), 1);
    check("t4_out_stable", int'(OUT), int'(held_out));
    check("t4_flags_stable", int'(FLAGS), int'(held_flags));
    IN_VALID = 0;
    OUT_READY = 1;
    repeat (4) tick();
    check("t4_queue_drained", sb_q.size(), 0);

    // Randomized traffic with random backpressure, including edge operands.
    done_rand = 0;
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          case ($urandom_range(0, 5))
            0: send_vec(4'h8, 4'h7, 1'($urandom), 1'($urandom), 1'($urandom));
            1: send_vec(4'h0, 4'hF, 1'($urandom), 1'($urandom), 1'($urandom));
            2: begin A = W'($urandom); send_vec(A, A, 1'($urandom), 1'($urandom), 1'($urandom)); end
            default: send_rand();
          endcase
          if ($urandom_range(0, 3) == 0) tick();
        end
        done_rand = 1;
      end
      begin
        while (!done_rand) begin
          OUT_READY = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    OUT_READY = 1;
    repeat (4) tick();
    check("rand_queue_drained", sb_q.size(), 0);

    // Narrow counters: saturate at 3, then clear wins over a handshake.
    IN_VALID_2 = 1; A_2 = 4'd7; B_2 = 4'd7; S2_2 = 1; S3_2 = 0;
    repeat (5) tick();
    IN_VALID_2 = 0;
    repeat (3) tick();
    check("t5_delivered", delivered_2, 5);
    check("t5_eq_sat", int'(EQ_CNT_2), (5 > 3) ? 3 : 5);
    check("t5_gt_zero", int'(GT_CNT_2), 0);
    check("t5_out", int'(OUT_2), 1);
    IN_VALID_2 = 1;
    tick();
    IN_VALID_2 = 0;
    tick();
    check("t5_valid_before_clr", int'(OUT_VALID_2), 1);
    CNT_CLR_2 = 1;
    tick();
    CNT_CLR_2 = 0;
    check("t5_eq_cleared", int'(EQ_CNT_2), 0);
    check("t5_delivered_on_clr", delivered_2, 6);
    check("t5_valid_after_clr", int'(OUT_VALID_2), 0);
    tick();
    check("t5_eq_stays_zero", int'(EQ_CNT_2), 0);

    // Async reset with both stages full.
    OUT_READY = 0;
    send_vec(4'd5, 4'd2, 1'b0, 1'b0, 1'b0);
    send_vec(4'd2, 4'd5, 1'b0, 1'b1, 1'b0);
    check("t6_full_valid", int'(OUT_VALID), 1);
    check("t6_full_in_ready", int'(IN_READY), 0);
    #2;
    RST = 1'b0;
    sb_q.delete();
    m_gt = 0; m_eq = 0; m_lt = 0;
    #1;
    check("t6_async_valid", int'(OUT_VALID), 0);
    check("t6_async_cnt", int'(GT_CNT) + int'(LT_CNT) + int'(EQ_CNT), 0);
    check("t6_async_cnt2", int'(EQ_CNT_2), 0);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    OUT_READY = 1;
    send_vec(4'd3, 4'd3, 1'b1, 1'b0, 1'b1);
    check("t6_post_valid_early", int'(OUT_VALID), 0);
    tick();
    check("t6_post_valid", int'(OUT_VALID), 1);
    check("t6_post_out", int'(OUT), 1);
    check("t6_post_flags", int'(FLAGS), 3'b010);
    repeat (2) tick();
    check("t6_eq_cnt", int'(EQ_CNT), 1);
    check("final_queue_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
